// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder: 4-bit groups feeding a group-level lookahead unit.
// Optional two's-complement overflow output enabled by defining CLA_ADDER_OVF_EN.
module cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef CLA_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum_comb;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  // Carry into group n, written as a flat sum of products over all lower groups
  // so the group carries are formed in parallel rather than rippled.
  function automatic logic group_carry(input logic [NG-1:0] ggv,
                                       input logic [NG-1:0] gpv,
                                       input logic          ci,
                                       input int            n);
    logic r;
    logic term;
    r = 1'b0;
    for (int k = -1; k < n; k++) begin
      term = (k < 0) ? ci : ggv[k];
      for (int m = k + 1; m < n; m++) begin
        term = term & gpv[m];
      end
      r = r | term;
    end
    return r;
  endfunction

  assign g     = a & b;
  assign p     = a ^ b;
  assign gc[0] = cin;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_group
      logic [3:0] gb;
      logic [3:0] pb;
      logic       ci;

      assign gb = g[4*gi +: 4];
      assign pb = p[4*gi +: 4];
      assign ci = gc[gi];

      assign gg[gi] = gb[3]
                    | (pb[3] & gb[2])
                    | (pb[3] & pb[2] & gb[1])
                    | (pb[3] & pb[2] & pb[1] & gb[0]);
      assign gp[gi] = &pb;

      assign c[4*gi]   = ci;
      assign c[4*gi+1] = gb[0] | (pb[0] & ci);
      assign c[4*gi+2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & ci);
      assign c[4*gi+3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                       | (pb[2] & pb[1] & pb[0] & ci);
    end

    for (genvar gi = 1; gi <= NG; gi++) begin : g_lookahead
      assign gc[gi] = group_carry(gg, gp, cin, gi);
    end
  endgenerate

  assign sum_comb = p ^ c;

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d  = sum_comb;
      cout_d = gc[NG];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

`ifdef CLA_ADDER_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the MSB disagrees with the carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = c[WIDTH-1] ^ gc[NG];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder.sv
// Directed and random checks for cla_adder at WIDTH=16; checks ovf when CLA_ADDER_OVF_EN is defined.
module tb_cla_adder;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
`ifdef CLA_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  cla_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef CLA_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic drive(input logic r, input logic v, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic c);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result(input string name, input logic [W-1:0] es, input logic ec,
                            input logic eo, input logic ev);
    chk({name, ".sum"}, 32'(sum), 32'(es));
    chk({name, ".cout"}, 32'(cout), 32'(ec));
    chk({name, ".out_valid"}, 32'(out_valid), 32'(ev));
`ifdef CLA_ADDER_OVF_EN
    chk({name, ".ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) chk({name, ".ovf_unused"}, 32'(eo), 32'd0);
`endif
  endtask

  initial begin
    vec_t           tbl[10];
    logic [W-1:0]   last_sum;
    logic           last_cout;
    logic           last_ovf;
    logic [W:0]     ref_full;
    logic           ref_ovf;

    tbl[0] = '{16'h00C8, 16'h0037, 1'b1, 16'h0100, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[6] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[7] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[9] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;

    // Reset asserted with live operands for two cycles: operands must be discarded.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b1);
      chk_result($sformatf("reset%0d", i), 16'h0000, 1'b0, 1'b0, 1'b0);
    end

    drive(1'b1, 1'b1, 16'h0005, 16'h0003, 1'b0);
    chk_result("first_after_reset", 16'h0008, 1'b0, 1'b0, 1'b1);

    // Directed table, applied back-to-back.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
      $display("vec %0d: a=%04h b=%04h cin=%0d -> sum=%04h cout=%0d", i, tbl[i].a, tbl[i].b,
               tbl[i].cin, sum, cout);
      chk_result($sformatf("tbl%0d", i), tbl[i].sum, tbl[i].cout, tbl[i].ovf, 1'b1);
    end

    // Idle gap: outputs hold the last result, out_valid drops.
    last_sum  = tbl[9].sum;
    last_cout = tbl[9].cout;
    last_ovf  = tbl[9].ovf;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
      chk_result($sformatf("hold%0d", i), last_sum, last_cout, last_ovf, 1'b0);
    end

    // Random streams: 20 narrow operands, then 1000 full-width, all back-to-back.
    for (int i = 0; i < 1020; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      if (i < 20) begin
        ra = W'($urandom_range(0, 255));
        rb = W'($urandom_range(0, 255));
      end else begin
        ra = W'($urandom);
        rb = W'($urandom);
      end
      rc       = 1'($urandom_range(0, 1));
      ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      ref_ovf  = (ra[W-1] == rb[W-1]) && (ref_full[W-1] != ra[W-1]);
      drive(1'b1, 1'b1, ra, rb, rc);
      if (i < 20) begin
        $display("rnd %0d: a=%04h b=%04h cin=%0d -> sum=%04h cout=%0d", i, ra, rb, rc, sum, cout);
      end
      chk_result($sformatf("rnd%0d", i), ref_full[W-1:0], ref_full[W], ref_ovf, 1'b1);
    end

    // Mid-stream reset, then a release edge with no valid input.
    drive(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1);
    chk_result("reset_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b1);
    chk_result("release_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'hFFF0, 16'h000F, 1'b1);
    chk_result("post_release", 16'h0000, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
